// File: rtl/wb_accel_arbiter_pkg.sv
// wb_accel_arbiter_pkg: shared state encoding and constants for the Wishbone accelerator arbiter
package wb_accel_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts stalled owned strobes and fires a one-cycle termination at TIMEOUT_CYCLES
//   clock, reset : clock and asynchronous active-high reset
//   stall        : owner strobe high while s_ack low this cycle
//   fire         : count reached TIMEOUT_CYCLES during a stall (terminate now)
//   flag         : sticky fired indicator, cleared only by reset (includes the firing cycle)
module wb_arb_watchdog
    import wb_accel_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic fire,
    output logic flag
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] count;
    logic          flag_q;
    assign fire = stall && (count == CW'(TIMEOUT_CYCLES));
    assign flag = flag_q | fire;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            flag_q <= 1'b0;
        end else begin
            count  <= (stall && !fire) ? count + CW'(1) : '0;
            flag_q <= flag_q | fire;
        end
    end
endmodule

// File: rtl/wb_accel_arbiter.sv
// wb_accel_arbiter: round-robin two-master Wishbone arbiter onto one accelerator slave (optional watchdog: ARB_TIMEOUT_EN)
//   clock, reset           : clock and asynchronous active-high reset
//   m0_* / m1_*            : requester cyc, stb, we, sel, addr, data_wr in; ack, data_rd out
//   s_*                    : shared slave bus out; s_ack, s_data_rd in
//   grant                  : one-hot owner {m1,m0}, 00 when idle
//   timeout_flag           : sticky watchdog indicator (tied 0 without ARB_TIMEOUT_EN)
module wb_accel_arbiter
    import wb_accel_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [27:0] m0_addr,
    input  logic [31:0] m0_data_wr,
    output logic        m0_ack,
    output logic [31:0] m0_data_rd,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [27:0] m1_addr,
    input  logic [31:0] m1_data_wr,
    output logic        m1_ack,
    output logic [31:0] m1_data_rd,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [27:0] s_addr,
    output logic [31:0] s_data_wr,
    input  logic        s_ack,
    input  logic [31:0] s_data_rd,
    output logic [1:0]  grant,
    output logic        timeout_flag
);
    state_t state, state_next;
    logic   last_owner, last_next;
    logic   req0, req1, own0, own1, fire;
    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;
    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            last_owner <= last_next;
        end
    end
    // last_owner: 1 means m1 owned last, so m0 wins the next tie
    always_comb begin
        state_next = state;
        last_next  = last_owner;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_owner)) begin
                    state_next = OWN0;
                    last_next  = 1'b0;
                end else if (req1) begin
                    state_next = OWN1;
                    last_next  = 1'b1;
                end
            end
            OWN0:    state_next = (!m0_cyc || fire) ? IDLE : OWN0;
            OWN1:    state_next = (!m1_cyc || fire) ? IDLE : OWN1;
            default: state_next = IDLE;
        endcase
    end
    assign grant      = {own1, own0};
    assign s_cyc      = ((own0 & m0_cyc) | (own1 & m1_cyc)) & ~fire;
    assign s_stb      = ((own0 & m0_stb) | (own1 & m1_stb)) & ~fire;
    assign s_we       = (own0 & m0_we) | (own1 & m1_we);
    assign s_sel      = own0 ? m0_sel : own1 ? m1_sel : '0;
    assign s_addr     = own0 ? m0_addr : own1 ? m1_addr : '0;
    assign s_data_wr  = own0 ? m0_data_wr : own1 ? m1_data_wr : '0;
    assign m0_ack     = own0 & (s_ack | fire);
    assign m1_ack     = own1 & (s_ack | fire);
    assign m0_data_rd = !own0 ? '0 : fire ? TIMEOUT_DATA : s_data_rd;
    assign m1_data_rd = !own1 ? '0 : fire ? TIMEOUT_DATA : s_data_rd;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
`ifdef ARB_TIMEOUT_EN
    logic stall;
    assign stall = ((own0 & m0_cyc & m0_stb) | (own1 & m1_cyc & m1_stb)) & ~s_ack;
    wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .fire(fire),
        .flag(timeout_flag)
    );
`else
    assign fire         = 1'b0;
    assign timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_wb_accel_arbiter.sv
// tb_wb_accel_arbiter: directed self-checking bench for wb_accel_arbiter
module tb_wb_accel_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [27:0] m0_addr = 0;
    logic [31:0] m0_data_wr = 0;
    logic        m0_ack;
    logic [31:0] m0_data_rd;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [27:0] m1_addr = 0;
    logic [31:0] m1_data_wr = 0;
    logic        m1_ack;
    logic [31:0] m1_data_rd;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [27:0] s_addr;
    logic [31:0] s_data_wr;
    logic        s_ack = 0;
    logic [31:0] s_data_rd = 0;
    logic [1:0]  grant;
    logic        timeout_flag;
    int          nvec = 0;
    int          nerr = 0;

    wb_accel_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_addr(m0_addr), .m0_data_wr(m0_data_wr), .m0_ack(m0_ack), .m0_data_rd(m0_data_rd),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_addr(m1_addr), .m1_data_wr(m1_data_wr), .m1_ack(m1_ack), .m1_data_rd(m1_data_rd),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_addr(s_addr), .s_data_wr(s_data_wr), .s_ack(s_ack), .s_data_rd(s_data_rd),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_data_wr = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_data_wr = 0;
        s_ack = 0; s_data_rd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; s_data_rd = 32'hCAFE0001;
        tick();
        tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL rst_grant: got %b want 00", grant); end
        nvec++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin nerr++; $display("FAIL rst_s_ctrl: got %b want 000", {s_cyc, s_stb, s_we}); end
        nvec++; if ({m0_ack, m1_ack} !== 2'b00) begin nerr++; $display("FAIL rst_acks: got %b want 00", {m0_ack, m1_ack}); end
        nvec++; if (timeout_flag !== 1'b0) begin nerr++; $display("FAIL rst_flag: got %b want 0", timeout_flag); end
        nvec++; if (m0_data_rd !== 32'h0) begin nerr++; $display("FAIL rst_m0_rd: got %h want 0", m0_data_rd); end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 28'h10;
        #1;
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL rd_pre_grant: got %b want 00", grant); end
        nvec++; if (s_cyc !== 1'b0) begin nerr++; $display("FAIL rd_pre_scyc: got %b want 0", s_cyc); end
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL rd_grant: got %b want 01", grant); end
        nvec++; if ({s_cyc, s_stb, s_we} !== 3'b110) begin nerr++; $display("FAIL rd_s_ctrl: got %b want 110", {s_cyc, s_stb, s_we}); end
        nvec++; if (s_addr !== 28'h10) begin nerr++; $display("FAIL rd_addr: got %h want 10", s_addr); end
        nvec++; if (s_sel !== 4'hF) begin nerr++; $display("FAIL rd_sel: got %h want f", s_sel); end
        nvec++; if ({m0_ack, m1_ack} !== 2'b00) begin nerr++; $display("FAIL rd_wait_ack: got %b want 00", {m0_ack, m1_ack}); end
        tick();
        nvec++; if (m0_ack !== 1'b0) begin nerr++; $display("FAIL rd_wait2_ack: got %b want 0", m0_ack); end
        s_ack = 1; s_data_rd = 32'h12345678;
        #1;
        nvec++; if (m0_ack !== 1'b1) begin nerr++; $display("FAIL rd_ack: got %b want 1", m0_ack); end
        nvec++; if (m0_data_rd !== 32'h12345678) begin nerr++; $display("FAIL rd_data: got %h want 12345678", m0_data_rd); end
        nvec++; if (m1_ack !== 1'b0) begin nerr++; $display("FAIL rd_m1_ack: got %b want 0", m1_ack); end
        nvec++; if (m1_data_rd !== 32'h0) begin nerr++; $display("FAIL rd_m1_data: got %h want 0", m1_data_rd); end
        tick();
        clear_inputs();
        #1;
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL rd_hold_grant: got %b want 01", grant); end
        nvec++; if (s_cyc !== 1'b0) begin nerr++; $display("FAIL rd_drop_scyc: got %b want 0", s_cyc); end
        tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL rd_idle: got %b want 00", grant); end
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 28'h20;
        m1_cyc = 1; m1_stb = 1; m1_addr = 28'h30;
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL tie_first: got %b want 01", grant); end
        nvec++; if (s_addr !== 28'h20) begin nerr++; $display("FAIL tie_addr0: got %h want 20", s_addr); end
        s_ack = 1;
        #1;
        nvec++; if ({m1_ack, m0_ack} !== 2'b01) begin nerr++; $display("FAIL tie_acks: got %b want 01", {m1_ack, m0_ack}); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL tie_dead: got %b want 00", grant); end
        nvec++; if (s_stb !== 1'b0) begin nerr++; $display("FAIL tie_dead_stb: got %b want 0", s_stb); end
        tick();
        nvec++; if (grant !== 2'b10) begin nerr++; $display("FAIL tie_second: got %b want 10", grant); end
        nvec++; if (s_addr !== 28'h30) begin nerr++; $display("FAIL tie_addr1: got %h want 30", s_addr); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3;
        tick();
        nvec++; if (grant !== 2'b10) begin nerr++; $display("FAIL b2b_grant: got %b want 10", grant); end
        m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 3; i++) begin
            m1_stb = 1; m1_addr = 28'h100 + 28'(i); m1_data_wr = 32'hA0 + 32'(i);
            s_ack = 1;
            #1;
            nvec++; if (s_addr !== 28'h100 + 28'(i)) begin nerr++; $display("FAIL b2b_addr%0d: got %h want %h", i, s_addr, 28'h100 + 28'(i)); end
            nvec++; if (s_data_wr !== 32'hA0 + 32'(i)) begin nerr++; $display("FAIL b2b_wdata%0d: got %h want %h", i, s_data_wr, 32'hA0 + 32'(i)); end
            nvec++; if ({s_stb, s_we} !== 2'b11) begin nerr++; $display("FAIL b2b_ctrl%0d: got %b want 11", i, {s_stb, s_we}); end
            nvec++; if ({m1_ack, m0_ack} !== 2'b10) begin nerr++; $display("FAIL b2b_acks%0d: got %b want 10", i, {m1_ack, m0_ack}); end
            tick();
            s_ack = 0; m1_stb = 0;
            tick();
            nvec++; if (grant !== 2'b10) begin nerr++; $display("FAIL b2b_keep%0d: got %b want 10", i, grant); end
        end
        m1_cyc = 0; m1_we = 0;
        tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL b2b_dead: got %b want 00", grant); end
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL b2b_m0_late: got %b want 01", grant); end
        clear_inputs();
        tick();
    endtask

    task automatic test_idle_ack();
        s_ack = 1; s_data_rd = 32'h55AA55AA;
        #1;
        nvec++; if ({m1_ack, m0_ack} !== 2'b00) begin nerr++; $display("FAIL idle_ack: got %b want 00", {m1_ack, m0_ack}); end
        nvec++; if (m0_data_rd !== 32'h0) begin nerr++; $display("FAIL idle_rd: got %h want 0", m0_data_rd); end
        tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL idle_stay: got %b want 00", grant); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        m1_cyc = 1; m1_stb = 1; m1_addr = 28'h44;
        tick();
        nvec++; if ({grant, s_stb} !== 3'b101) begin nerr++; $display("FAIL mid_pre: got %b want 101", {grant, s_stb}); end
        #2;
        reset = 1'b1; s_ack = 1;
        #1;
        nvec++; if (s_stb !== 1'b0) begin nerr++; $display("FAIL mid_stb: got %b want 0", s_stb); end
        nvec++; if (s_cyc !== 1'b0) begin nerr++; $display("FAIL mid_cyc: got %b want 0", s_cyc); end
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL mid_grant: got %b want 00", grant); end
        nvec++; if (m1_ack !== 1'b0) begin nerr++; $display("FAIL mid_ack: got %b want 0", m1_ack); end
        tick();
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        m0_cyc = 1; m0_stb = 1; m0_addr = 28'h77;
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL to_grant: got %b want 01", grant); end
        for (int i = 0; i < 8; i++) begin
            nvec++; if (m0_ack !== 1'b0) begin nerr++; $display("FAIL to_stall%0d: got %b want 0", i, m0_ack); end
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        nvec++; if (m0_ack !== 1'b1) begin nerr++; $display("FAIL to_ack: got %b want 1", m0_ack); end
        nvec++; if (m0_data_rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL to_data: got %h want deadbeef", m0_data_rd); end
        nvec++; if ({s_cyc, s_stb} !== 2'b00) begin nerr++; $display("FAIL to_sbus: got %b want 00", {s_cyc, s_stb}); end
        nvec++; if (timeout_flag !== 1'b1) begin nerr++; $display("FAIL to_flag: got %b want 1", timeout_flag); end
        tick();
        clear_inputs();
        #1;
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL to_idle: got %b want 00", grant); end
        nvec++; if (timeout_flag !== 1'b1) begin nerr++; $display("FAIL to_sticky: got %b want 1", timeout_flag); end
        tick();
        tick();
        nvec++; if (timeout_flag !== 1'b1) begin nerr++; $display("FAIL to_sticky2: got %b want 1", timeout_flag); end
`else
        tick();
        tick();
        nvec++; if ({grant, m0_ack} !== 3'b010) begin nerr++; $display("FAIL nto_wait: got %b want 010", {grant, m0_ack}); end
        nvec++; if (timeout_flag !== 1'b0) begin nerr++; $display("FAIL nto_flag: got %b want 0", timeout_flag); end
        nvec++; if (s_stb !== 1'b1) begin nerr++; $display("FAIL nto_stb: got %b want 1", s_stb); end
        s_ack = 1; s_data_rd = 32'h0BADF00D;
        #1;
        nvec++; if (m0_data_rd !== 32'h0BADF00D) begin nerr++; $display("FAIL nto_data: got %h want 0badf00d", m0_data_rd); end
        tick();
        clear_inputs();
        tick();
`endif
        do_reset();
        nvec++; if (timeout_flag !== 1'b0) begin nerr++; $display("FAIL to_clr: got %b want 0", timeout_flag); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
